// File: rtl/time_display_scan.sv
// time_display_scan: multiplexed 4-digit mm:ss seven-segment driver.
// Inputs are sampled once per frame; the whole display can be flashed.
module time_display_scan #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 50000000
) (
   input  logic       timer,
   input  logic       reset,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       blink_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

   function automatic logic [3:0] tens_of(input logic [5:0] v);
      logic [3:0] t;
      t = 4'd0;
      if (v >= 6'd60)      t = 4'd6;
      else if (v >= 6'd50) t = 4'd5;
      else if (v >= 6'd40) t = 4'd4;
      else if (v >= 6'd30) t = 4'd3;
      else if (v >= 6'd20) t = 4'd2;
      else if (v >= 6'd10) t = 4'd1;
      return t;
   endfunction

   function automatic logic [3:0] ones_of(
      input logic [5:0] v,
      input logic [3:0] t
   );
      return 4'(v - ({2'b00, t} * 6'd10));
   endfunction

   // Patterns are {g,f,e,d,c,b,a}, active low.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [5:0]    min_snap_q, min_snap_d;
   logic [5:0]    sec_snap_q, sec_snap_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          digit_tick;
   logic          blank;
   logic [3:0]    min_tens, sec_tens;
   logic [3:0]    digit;

   assign min_tens = tens_of(min_snap_q);
   assign sec_tens = tens_of(sec_snap_q);

   always_comb begin
      digit_tick    = (refresh_cnt_q == REF_LAST);
      refresh_cnt_d = digit_tick ? '0 : refresh_cnt_q + RW'(1);
      idx_d         = digit_tick ? idx_q + 2'd1 : idx_q;
      min_snap_d    = min_snap_q;
      sec_snap_d    = sec_snap_q;
      // Snapshot on the last tick of a frame so a frame never mixes values.
      if (digit_tick && (idx_q == 2'd3)) begin
         min_snap_d = minutes;
         sec_snap_d = seconds;
      end
   end

   always_comb begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      if (blink_en) begin
         if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d   = blink_cnt_q + BW'(1);
            blink_phase_d = blink_phase_q;
         end
      end
   end

   always_comb begin
      digit = 4'd0;
      unique case (idx_q)
         2'd0: digit = ones_of(sec_snap_q, sec_tens);
         2'd1: digit = sec_tens;
         2'd2: digit = ones_of(min_snap_q, min_tens);
         2'd3: digit = min_tens;
      endcase
      blank = blink_en & blink_phase_q;
      an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d = seg7(digit);
      dp_d  = blank | (idx_q != 2'd2);
   end

   always_ff @(posedge timer) begin
      if (reset) begin
         refresh_cnt_q <= '0;
         idx_q         <= 2'd0;
         min_snap_q    <= 6'd0;
         sec_snap_q    <= 6'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         an_q          <= 4'b1111;
         seg_q         <= 7'b1111111;
         dp_q          <= 1'b1;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
         idx_q         <= idx_d;
         min_snap_q    <= min_snap_d;
         sec_snap_q    <= sec_snap_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with short refresh and blink
// periods; every output cycle of each frame is compared to a table.
module tb_time_display_scan;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S9 = 7'b0010000;

   logic       timer = 1'b0;
   logic       reset;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       blink_en;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_chk  = 0;
   int n_fail = 0;
   int frame  = 0;

   time_display_scan #(
      .REFRESH_DIV(4),
      .BLINK_DIV  (8)
   ) dut (
      .timer   (timer),
      .reset   (reset),
      .minutes (minutes),
      .seconds (seconds),
      .blink_en(blink_en),
      .an      (an),
      .seg     (seg),
      .dp      (dp)
   );

   always #5 timer = ~timer;

   task automatic chk(
      input string      tag,
      input logic [6:0] got,
      input logic [6:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Checks n output cycles of one frame; blank_m marks blanked cycles.
   // act fires after the check of cycle act_at: 1 = seconds->35,
   // 2 = drop blink_en.
   task automatic run_frame(
      input logic [6:0]  s0,
      input logic [6:0]  s1,
      input logic [6:0]  s2,
      input logic [6:0]  s3,
      input logic [15:0] blank_m,
      input int          n,
      input int          act_at,
      input int          act
   );
      logic [6:0] sx [4];
      sx[0] = s0;
      sx[1] = s1;
      sx[2] = s2;
      sx[3] = s3;
      for (int k = 0; k < n; k++) begin
         int         d;
         logic [3:0] one;
         logic [3:0] exp_an;
         logic       exp_dp;
         d = k / 4;
         @(posedge timer);
         @(negedge timer);
         one = 4'b0001 << d;
         if (blank_m[k]) begin
            exp_an = 4'b1111;
            exp_dp = 1'b1;
         end else begin
            exp_an = ~one;
            exp_dp = (d == 2) ? 1'b0 : 1'b1;
         end
         chk($sformatf("f%0d c%0d an", frame, k), 7'(an), 7'(exp_an));
         chk($sformatf("f%0d c%0d seg", frame, k), seg, sx[d]);
         chk($sformatf("f%0d c%0d dp", frame, k), 7'(dp), 7'(exp_dp));
         if (k == act_at) begin
            case (act)
               1:       seconds = 6'd35;
               2:       blink_en = 1'b0;
               default: ;
            endcase
         end
      end
      frame++;
   endtask

   initial begin
      reset    = 1'b1;
      minutes  = 6'd12;
      seconds  = 6'd34;
      blink_en = 1'b0;
      repeat (2) @(posedge timer);
      @(negedge timer);
      chk("rst an", 7'(an), 7'(4'b1111));
      chk("rst seg", seg, 7'b1111111);
      chk("rst dp", 7'(dp), 7'(1'b1));
      reset = 1'b0;

      run_frame(S0, S0, S0, S0, 16'h0000, 16, -1, 0);
      run_frame(S4, S3, S2, S1, 16'h0000, 16, -1, 0);
      run_frame(S4, S3, S2, S1, 16'h0000, 16, 4, 1);
      minutes = 6'd60;
      seconds = 6'd59;
      run_frame(S5, S3, S2, S1, 16'h0000, 16, -1, 0);
      run_frame(S9, S5, S0, S6, 16'h0000, 16, -1, 0);

      blink_en = 1'b1;
      run_frame(S9, S5, S0, S6, 16'hFF00, 16, -1, 0);
      run_frame(S9, S5, S0, S6, 16'hFF00, 16, -1, 0);
      run_frame(S9, S5, S0, S6, 16'h0100, 16, 8, 2);

      run_frame(S9, S5, S0, S6, 16'h0000, 9, -1, 0);
      reset = 1'b1;
      @(posedge timer);
      @(negedge timer);
      chk("mid rst an", 7'(an), 7'(4'b1111));
      chk("mid rst seg", seg, 7'b1111111);
      chk("mid rst dp", 7'(dp), 7'(1'b1));
      reset = 1'b0;
      run_frame(S0, S0, S0, S0, 16'h0000, 16, -1, 0);
      run_frame(S9, S5, S0, S6, 16'h0000, 16, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
